// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the fabric configuration loader and its benches.
package cfg_loader_pkg;

    // Default switch-box geometry; the frame carries the box ID in the low bits.
    localparam int unsigned ID_WIDTH       = 3;
    localparam int unsigned CHN_WIDTH      = 16;
    localparam int unsigned DEF_FRAME_BITS = ID_WIDTH + CHN_WIDTH * 8;

    // Sequencer state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Host words needed to carry one frame (ceiling divide).
    function automatic int unsigned cfg_wpf(input int unsigned bits, input int unsigned width);
        return (bits + width - 1) / width;
    endfunction

endpackage

// File: rtl/cfg_frame_buf.sv
// One-frame buffer: written a host word at a time, read out one bit at a time.
module cfg_frame_buf
    import cfg_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned WPF        = 5,
    parameter int unsigned WIDX_W     = 3,
    parameter int unsigned BIT_W      = 8
) (
    input  logic                  clk,
    input  logic                  crst,
    input  logic                  we_i,
    input  logic [WIDX_W-1:0]     widx_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    input  logic [BIT_W-1:0]      ridx_i,
    output logic                  rbit_o
);

    logic [WPF*WORD_WIDTH-1:0] mem_q;

    // Store the incoming word at its slot; reset clears any partial frame.
    always_ff @(posedge clk) begin
        if (crst) begin
            mem_q <= '0;
        end else if (we_i) begin
            for (int unsigned w = 0; w < WPF; w++) begin
                if (widx_i == WIDX_W'(w)) begin
                    mem_q[w*WORD_WIDTH +: WORD_WIDTH] <= wdata_i;
                end
            end
        end
    end

    assign rbit_o = mem_q[ridx_i];

endmodule

// File: rtl/cfg_loader.sv
// Config chain sequencer: buffers one host frame, then shifts it LSB first
// into the chain behind a start pulse, followed by a settle gap.
module cfg_loader
    import cfg_loader_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  crst,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    input  logic                  wr_last,
    output logic                  wr_ready,
    output logic                  cfg_in_start,
    output logic                  cfg_bit_in,
    output logic                  busy,
    output logic                  cfg_done,
    output logic [CNT_WIDTH-1:0]  frame_cnt
);

    localparam int unsigned WPF    = cfg_wpf(FRAME_BITS, WORD_WIDTH);
    localparam int unsigned WIDX_W = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int unsigned BIT_W  = (WPF * WORD_WIDTH > 1) ? $clog2(WPF * WORD_WIDTH) : 1;
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [WIDX_W-1:0] WORD_LAST = WIDX_W'(WPF - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [WIDX_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 last_q, last_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

    logic wr_ready_q, wr_ready_d;
    logic cfg_in_start_q, cfg_in_start_d;
    logic cfg_bit_in_q, cfg_bit_in_d;
    logic busy_q, busy_d;
    logic cfg_done_q, cfg_done_d;

    logic             wr_fire;
    logic [BIT_W-1:0] rd_idx;
    logic             rd_bit;

    assign wr_fire = wr_valid && wr_ready_q;

    cfg_frame_buf #(
        .WORD_WIDTH (WORD_WIDTH),
        .WPF        (WPF),
        .WIDX_W     (WIDX_W),
        .BIT_W      (BIT_W)
    ) u_buf (
        .clk     (clk),
        .crst    (crst),
        .we_i    (wr_fire),
        .widx_i  (word_cnt_q),
        .wdata_i (wr_data),
        .ridx_i  (rd_idx),
        .rbit_o  (rd_bit)
    );

    // Next-state and counter logic; rd_idx looks one bit ahead so cfg_bit_in can be registered.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        last_d      = last_q;
        frame_cnt_d = frame_cnt_q;
        rd_idx      = '0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (wr_fire) begin
                    if (word_cnt_q == WORD_LAST) begin
                        state_d    = ST_START;
                        word_cnt_d = '0;
                        last_d     = wr_last;
                    end else begin
                        state_d    = ST_LOAD;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            ST_START: begin
                state_d   = ST_SHIFT;
                bit_cnt_d = '0;
                rd_idx    = '0;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    state_d     = ST_GAP;
                    gap_cnt_d   = '0;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    rd_idx    = bit_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = last_q ? ST_IDLE : ST_LOAD;
                    word_cnt_d = '0;
                    gap_cnt_d  = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        wr_ready_d     = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        cfg_in_start_d = (state_d == ST_START);
        cfg_bit_in_d   = (state_d == ST_SHIFT) && rd_bit;
        busy_d         = (state_d != ST_IDLE);
        cfg_done_d     = last_q && (state_d == ST_GAP) && (gap_cnt_d == GAP_LAST);
    end

    // State, counters and registered outputs, all cleared by crst.
    always_ff @(posedge clk) begin
        if (crst) begin
            state_q        <= ST_IDLE;
            word_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            last_q         <= 1'b0;
            frame_cnt_q    <= '0;
            wr_ready_q     <= 1'b0;
            cfg_in_start_q <= 1'b0;
            cfg_bit_in_q   <= 1'b0;
            busy_q         <= 1'b0;
            cfg_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            last_q         <= last_d;
            frame_cnt_q    <= frame_cnt_d;
            wr_ready_q     <= wr_ready_d;
            cfg_in_start_q <= cfg_in_start_d;
            cfg_bit_in_q   <= cfg_bit_in_d;
            busy_q         <= busy_d;
            cfg_done_q     <= cfg_done_d;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign cfg_in_start = cfg_in_start_q;
    assign cfg_bit_in   = cfg_bit_in_q;
    assign busy         = busy_q;
    assign cfg_done     = cfg_done_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader with default parameters (5 words x 32 bits, 131-bit frames, gap 4).
module tb_cfg_loader;

    logic        clk;
    logic        crst;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic        wr_ready;
    logic        cfg_in_start;
    logic        cfg_bit_in;
    logic        busy;
    logic        cfg_done;
    logic [7:0]  frame_cnt;

    cfg_loader #(
        .WORD_WIDTH (32),
        .FRAME_BITS (131),
        .GAP_CYCLES (4),
        .CNT_WIDTH  (8)
    ) dut (
        .clk          (clk),
        .crst         (crst),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .cfg_in_start (cfg_in_start),
        .cfg_bit_in   (cfg_bit_in),
        .busy         (busy),
        .cfg_done     (cfg_done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [159:0] data;
        logic [4:0]   lastm;
        int unsigned  space;
        logic [130:0] exp_bits;
        logic         exp_last;
    } vec_t;

    typedef struct {
        logic [130:0] bits;
        logic         last;
    } sb_t;

    vec_t        tbl [6];
    sb_t         sb_q [$];
    sb_t         cur;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned cyc;
    int unsigned last_hs_cyc;
    int unsigned prev_start;
    int unsigned done_seen;
    int unsigned spur_done;
    int unsigned exp_done_total;
    int unsigned shape_bad;
    int          ph;
    logic        in_frame;
    logic        have_prev;
    logic [7:0]  exp_fc;
    logic [130:0] cap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [130:0] act, input logic [130:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Drive one frame word by word; the expectation is queued just before the final handshake.
    task automatic send_frame(input logic [159:0] data, input logic [4:0] lastm, input int unsigned space,
                              input logic [130:0] exp_bits, input logic exp_last);
        for (int k = 0; k < 5; k++) begin
            int unsigned t;
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = data[k*32 +: 32];
            wr_last  = lastm[k];
            t = 0;
            while (wr_ready !== 1'b1 && t < 400) begin
                @(negedge clk);
                t++;
            end
            check("wr_ready_seen", 131'(wr_ready), 131'd1);
            if (wr_ready !== 1'b1) begin
                wr_valid = 1'b0;
                return;
            end
            if (k == 4) sb_q.push_back('{bits: exp_bits, last: exp_last});
            @(posedge clk);
            #1;
            if (k == 4) last_hs_cyc = cyc;
            wr_valid = 1'b0;
            wr_last  = 1'b1;
            wr_data  = $urandom;
            repeat (space) @(negedge clk);
        end
        wr_last = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        @(negedge clk);
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", 131'(busy), '0);
    endtask

    // Monitor: frames the serial stream around each start pulse and checks it against the scoreboard.
    initial begin
        in_frame  = 1'b0;
        have_prev = 1'b0;
        exp_fc    = '0;
        ph        = 0;
        shape_bad = 0;
        cap       = '0;
        forever begin
            @(negedge clk);
            if (crst) begin
                in_frame  = 1'b0;
                have_prev = 1'b0;
                exp_fc    = '0;
            end else begin
                if (in_frame) ph++;
                if (cfg_done) begin
                    done_seen++;
                    if (!(in_frame && ph == 135)) spur_done++;
                end
                if (in_frame) begin
                    if (ph <= 135 && (wr_ready || cfg_in_start)) shape_bad++;
                    if (ph >= 1 && ph <= 131) cap[ph-1] = cfg_bit_in;
                    if (ph >= 132 && cfg_bit_in) shape_bad++;
                    if (ph == 131) begin
                        check("serial_bits", cap, cur.bits);
                        check("frame_cnt_before_gap", 131'(frame_cnt), 131'(exp_fc));
                        exp_fc = exp_fc + 8'd1;
                    end
                    if (ph == 132) check("frame_cnt_in_gap", 131'(frame_cnt), 131'(exp_fc));
                    if (ph == 135) check("done_at_gap_end", 131'(cfg_done), 131'(cur.last));
                    if (ph == 136) begin
                        check("busy_after_gap", 131'(busy), 131'(!cur.last));
                        check("ready_after_gap", 131'(wr_ready), 131'd1);
                        check("frame_shape", 131'(shape_bad), '0);
                        in_frame = 1'b0;
                    end
                end else if (cfg_in_start) begin
                    check("start_latency", 131'(cyc - last_hs_cyc), '0);
                    if (have_prev) check("start_spacing", 131'((cyc - prev_start) >= 141), 131'd1);
                    check("sb_nonempty", 131'(sb_q.size() != 0), 131'd1);
                    if (sb_q.size() != 0) cur = sb_q.pop_front();
                    else cur = '{bits: '0, last: 1'b0};
                    have_prev  = 1'b1;
                    prev_start = cyc;
                    in_frame   = 1'b1;
                    ph         = 0;
                    cap        = '0;
                    shape_bad  = (wr_ready || cfg_bit_in) ? 1 : 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        logic [159:0] d1, da, db, dp1, dp2;
        logic [130:0] e1, ep1, ep2;
        logic [130:0] ones;
        int unsigned  t;

        clk = 1'b0; crst = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; wr_data = '0;
        n_vec = 0; n_err = 0; cyc = 0; last_hs_cyc = 0; prev_start = 0;
        done_seen = 0; spur_done = 0; exp_done_total = 0;

        d1  = {32'h0000_0004, 32'h0, 32'h0, 32'h0000_0100, 32'h0000_0007};
        e1  = '0;
        e1[130] = 1'b1; e1[40] = 1'b1; e1[2:0] = 3'b111;
        da  = {32'h0000_0005, 32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_5A5A, 32'h8000_0001};
        db  = {32'h0000_0002, 32'h0F0F_F0F0, 32'hFFFF_0000, 32'h0000_FFFF, 32'hC3C3_3C3C};
        dp1 = {32'hFFFF_FFF8, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        ep1 = {3'b000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        dp2 = {32'hFFFF_FFFD, 128'h0};
        ep2 = {3'b101, 128'h0};
        ones = '1;

        tbl[0] = '{data: d1,  lastm: 5'b10000, space: 0, exp_bits: e1,         exp_last: 1'b1};
        tbl[1] = '{data: da,  lastm: 5'b00000, space: 0, exp_bits: da[130:0],  exp_last: 1'b0};
        tbl[2] = '{data: db,  lastm: 5'b10000, space: 0, exp_bits: db[130:0],  exp_last: 1'b1};
        tbl[3] = '{data: d1,  lastm: 5'b10000, space: 2, exp_bits: e1,         exp_last: 1'b1};
        tbl[4] = '{data: dp1, lastm: 5'b00100, space: 0, exp_bits: ep1,        exp_last: 1'b0};
        tbl[5] = '{data: dp2, lastm: 5'b10000, space: 1, exp_bits: ep2,        exp_last: 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 131'({wr_ready, cfg_in_start, cfg_bit_in, busy, cfg_done, frame_cnt}), '0);
        crst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 131'({wr_ready, busy}), 131'(2'b10));

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].data, tbl[i].lastm, tbl[i].space, tbl[i].exp_bits, tbl[i].exp_last);
            if (tbl[i].exp_last) exp_done_total++;
        end
        wait_idle();

        // Abort a dense frame while bit 60 is on the chain.
        send_frame({160{1'b1}}, 5'b10000, 0, ones, 1'b1);
        t = 0;
        @(negedge clk);
        while (!cfg_in_start && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mid_shift_start_seen", 131'(cfg_in_start), 131'd1);
        repeat (61) @(negedge clk);
        crst = 1'b1;
        @(negedge clk);
        check("reset_mid_shift", 131'({cfg_bit_in, cfg_in_start, busy, cfg_done, wr_ready, frame_cnt}), '0);
        @(posedge clk);
        #1;
        crst = 1'b0;

        send_frame(d1, 5'b10000, 0, e1, 1'b1);
        exp_done_total++;
        wait_idle();
        repeat (5) @(negedge clk);

        check("done_count", 131'(done_seen), 131'(exp_done_total));
        check("spurious_done", 131'(spur_done), '0);
        check("scoreboard_drained", 131'(sb_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
